ps2_kbd_tx: RTL and testbench

//  PS/2 device-side transmitter: the sending end of the PS/2 link whose receiving end is the keyboard decoder.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_tx_fifo.sv | 61 ++++++
 rtl/ps2_kbd_tx.sv | 176 +++++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device-side transmitter.
package ps2_pkg;

    // Transmitter FSM states: waiting, clock-high half, clock-low half, inter-frame gap.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        GAP  = 2'd3
    } ps2_tx_state_t;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    // Odd parity bit for a PS/2 data byte.
    function automatic logic ps2_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Scan-code FIFO, first-word-fall-through: dout always shows the head entry.
// A write while full is accepted only when a read happens in the same cycle.
module ps2_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic [7:0]                 din,
    input  logic                       wr,
    input  logic                       rd,
    output logic [7:0]                 dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_count == (PW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_pop  = rd && !empty;
    assign w_push = wr && (!full || w_pop);
    assign dout   = r_mem[r_rd_ptr];
    assign count  = r_count;

    // Storage array: written on every accepted push, never reset.
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: queues scan codes and serialises each into an
// 11-bit frame on ps2_kbd_clk/ps2_kbd_data. Data changes at the start of the
// clock-high half of each bit so the receiver sees it stable on the falling edge.
// Handshake: wr is a one-cycle strobe; a byte is accepted when the FIFO is not
// full, or when it is full and the head is popped in that same cycle.
// The inter-frame gap is GAP_CYCLES high cycles: GAP_CYCLES-1 in GAP plus the
// IDLE cycle that follows, so GAP_CYCLES must be at least 2.
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 2000,
    parameter int GAP_CYCLES  = 4000,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       wr,
    input  logic       inhibit,
    output logic       full,
    output logic       overflow,
    output logic       busy,
    output logic       ps2_kbd_clk,
    output logic       ps2_kbd_data
);

    localparam int          MAX_CNT  = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int          CNT_W    = $clog2(MAX_CNT + 1);
    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0]  LAST_IDX = 4'(PS2_FRAME_BITS - 1);

    ps2_tx_state_t r_state;
    ps2_tx_state_t w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_idx;
    logic [10:0]      r_shift;
    logic             r_clk;
    logic             r_data;
    logic             r_overflow;

    logic             w_load;
    logic             w_advance;
    logic             w_pop;
    logic             w_half_done;
    logic             w_gap_done;
    logic [7:0]       w_head;
    logic [CW-1:0]    w_count;
    logic             w_full;
    logic             w_empty;

    ps2_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .din     (din),
        .wr      (wr),
        .rd      (w_pop),
        .dout    (w_head),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign w_half_done = (r_cnt == CNT_W'(HALF_PERIOD - 1));
    assign w_gap_done  = (r_cnt == CNT_W'(GAP_CYCLES - 2));

    // Next-state and control strobes; inhibit aborts a running frame without popping.
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_advance = 1'b0;
        w_pop     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !inhibit) begin
                    w_next = HIGH;
                    w_load = 1'b1;
                end
            end
            HIGH: begin
                if (inhibit) begin
                    w_next = GAP;
                end else if (w_half_done) begin
                    w_next = LOW;
                end
            end
            LOW: begin
                if (inhibit) begin
                    w_next = GAP;
                end else if (w_half_done) begin
                    if (r_idx == LAST_IDX) begin
                        w_next = GAP;
                        w_pop  = 1'b1;
                    end else begin
                        w_next    = HIGH;
                        w_advance = 1'b1;
                    end
                end
            end
            GAP: begin
                if (w_gap_done) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Phase counter: restarts on every state change, held at zero while idle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((w_next != r_state) || (r_state == IDLE)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Bit index and remaining-bits shift register; loaded from the FIFO head at frame start.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_idx   <= '0;
            r_shift <= '1;
        end else if (w_load) begin
            r_idx   <= '0;
            r_shift <= {1'b1, 1'b1, ps2_parity(w_head), w_head};
        end else if (w_advance) begin
            r_idx   <= r_idx + 1'b1;
            r_shift <= {1'b1, r_shift[10:1]};
        end
    end

    // Registered line drivers: clock low only in LOW, data updated on entry to HIGH.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk  <= 1'b1;
            r_data <= 1'b1;
        end else begin
            r_clk <= (w_next != LOW);
            if (w_load) begin
                r_data <= 1'b0;
            end else if (w_advance) begin
                r_data <= r_shift[0];
            end else if ((w_next == GAP) || (w_next == IDLE)) begin
                r_data <= 1'b1;
            end
        end
    end

    // Sticky overflow: a write that the FIFO could not accept.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (wr && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign ps2_kbd_clk  = r_clk;
    assign ps2_kbd_data = r_data;
    assign full         = w_full;
    assign overflow     = r_overflow;
    assign busy         = (r_state != IDLE) || (w_count != '0);

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: PS/2 receiver model plus expected-byte scoreboard.
module tb_ps2_kbd_tx;

    localparam int HP    = 4;
    localparam int GAP   = 8;
    localparam int DEPTH = 16;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] din     = 8'h00;
    logic       wr      = 1'b0;
    logic       inhibit = 1'b0;
    logic       full;
    logic       overflow;
    logic       busy;
    logic       ps2_kbd_clk;
    logic       ps2_kbd_data;

    ps2_kbd_tx #(
        .HALF_PERIOD (HP),
        .GAP_CYCLES  (GAP),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .din          (din),
        .wr           (wr),
        .inhibit      (inhibit),
        .full         (full),
        .overflow     (overflow),
        .busy         (busy),
        .ps2_kbd_clk  (ps2_kbd_clk),
        .ps2_kbd_data (ps2_kbd_data)
    );

    // Clock and watchdog.
    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Receiver model: samples data on falling ps2_kbd_clk, drops partial frames
    // when the clock stays high longer than a normal high phase.
    logic        rx_prev_clk = 1'b1;
    int          rx_bit      = 0;
    int          rx_hi       = 0;
    int          rx_edges    = 0;
    int          rx_frames   = 0;
    logic [10:0] rx_sh       = '0;

    always @(negedge clk_sys) begin : rx_model
        logic [10:0] f;
        if (reset) begin
            rx_bit      <= 0;
            rx_hi       <= 0;
            rx_prev_clk <= 1'b1;
        end else begin
            rx_prev_clk <= ps2_kbd_clk;
            rx_hi       <= ps2_kbd_clk ? rx_hi + 1 : 0;
            if (rx_prev_clk && !ps2_kbd_clk) begin
                rx_edges <= rx_edges + 1;
                f = {ps2_kbd_data, rx_sh[10:1]};
                rx_sh <= f;
                if (rx_bit == 10) begin
                    rx_bit    <= 0;
                    rx_frames <= rx_frames + 1;
                    check("rx_start", f[0], 1'b0);
                    check("rx_stop", f[10], 1'b1);
                    check("rx_parity", f[9], ~^f[8:1]);
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected_frame", f[8:1], 32'hFFFF_FFFF);
                    end else begin
                        check("rx_byte", f[8:1], exp_q.pop_front());
                    end
                end else begin
                    rx_bit <= rx_bit + 1;
                end
            end else if (rx_hi > HP + 2) begin
                rx_bit <= 0;
            end
        end
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(posedge clk_sys);
        #1;
        din = b;
        wr  = 1'b1;
        @(posedge clk_sys);
        #1;
        wr  = 1'b0;
    endtask

    task automatic wait_busy_low(input int bound, input string tag);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic wait_rx_bit(input int v, input string tag);
        int n = 0;
        while (rx_bit != v && n < 2000) begin
            tick();
            n++;
        end
        check(tag, rx_bit, v);
    endtask

    task automatic wait_frames(input int v, input string tag);
        int n = 0;
        while (rx_frames != v && n < 2000) begin
            tick();
            n++;
        end
        check(tag, rx_frames, v);
    endtask

    task automatic wait_line(input logic want_clk, input logic lvl, input string tag);
        int n = 0;
        while (((want_clk ? ps2_kbd_clk : ps2_kbd_data) != lvl) && n < 2000) begin
            tick();
            n++;
        end
        check(tag, want_clk ? ps2_kbd_clk : ps2_kbd_data, lvl);
    endtask

    initial begin
        int         n_clk;
        int         n_busy;
        int         g;
        int         f0;
        int         e0;
        logic [7:0] b;

        repeat (4) tick();
        reset = 1'b0;
        tick();
        check("rst_clk", ps2_kbd_clk, 1'b1);
        check("rst_data", ps2_kbd_data, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_busy", busy, 1'b0);

        // 1: single 0x1C frame, latency and length
        exp_q.push_back(8'h1C);
        write_byte(8'h1C);
        check("t1_data_before_start", ps2_kbd_data, 1'b1);
        tick();
        check("t1_data_start", ps2_kbd_data, 1'b0);
        n_clk  = -1;
        n_busy = -1;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (n_clk < 0 && !ps2_kbd_clk) n_clk = n;
            if (!busy) begin
                n_busy = n;
                break;
            end
        end
        check("t1_first_clk_fall", n_clk, 4);
        check("t1_busy_low_cycles", n_busy, 95);
        check("t1_edges", rx_edges, 11);
        check("t1_frames", rx_frames, 1);
        check("t1_queue_empty", exp_q.size(), 0);

        // 2: two frames back-to-back, gap length
        f0 = rx_frames;
        exp_q.push_back(8'hF0);
        write_byte(8'hF0);
        exp_q.push_back(8'h1C);
        write_byte(8'h1C);
        wait_frames(f0 + 1, "t2_first_frame");
        wait_line(1'b1, 1'b1, "t2_stop_low_end");
        g = 0;
        while (ps2_kbd_clk && ps2_kbd_data && g < 100) begin
            g++;
            tick();
        end
        check("t2_gap_high_cycles", g, GAP);
        check("t2_next_start", ps2_kbd_data, 1'b0);
        wait_busy_low(500, "t2_busy_low");
        check("t2_frames", rx_frames, f0 + 2);
        check("t2_queue_empty", exp_q.size(), 0);

        // 3: fill while inhibited, overflow, then drain in order
        f0 = rx_frames;
        inhibit = 1'b1;
        tick();
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < DEPTH) exp_q.push_back(b);
            write_byte(b);
            if (i == DEPTH - 2) check("t3_not_full_15", full, 1'b0);
            if (i == DEPTH - 1) begin
                check("t3_full_16", full, 1'b1);
                check("t3_no_overflow_16", overflow, 1'b0);
            end
            if (i == DEPTH) begin
                check("t3_full_17", full, 1'b1);
                check("t3_overflow_17", overflow, 1'b1);
            end
        end
        check("t3_clk_idle", ps2_kbd_clk, 1'b1);
        check("t3_busy_queued", busy, 1'b1);
        inhibit = 1'b0;
        wait_busy_low(5000, "t3_busy_low");
        check("t3_frames", rx_frames, f0 + DEPTH);
        check("t3_queue_empty", exp_q.size(), 0);

        // 4: inhibit during bit 5 low phase, frame resent
        f0 = rx_frames;
        exp_q.push_back(8'h5A);
        write_byte(8'h5A);
        wait_rx_bit(6, "t4_reach_bit5_low");
        check("t4_clk_low_bit5", ps2_kbd_clk, 1'b0);
        inhibit = 1'b1;
        tick();
        check("t4_abort_clk", ps2_kbd_clk, 1'b1);
        check("t4_abort_data", ps2_kbd_data, 1'b1);
        repeat (20) tick();
        check("t4_busy_held", busy, 1'b1);
        check("t4_no_frame_yet", rx_frames, f0);
        inhibit = 1'b0;
        wait_busy_low(500, "t4_busy_low");
        check("t4_frames", rx_frames, f0 + 1);
        check("t4_queue_empty", exp_q.size(), 0);

        // 5: reset mid-frame discards queued bytes
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        wait_rx_bit(4, "t5_reach_bit3");
        reset = 1'b1;
        tick();
        check("t5_clk", ps2_kbd_clk, 1'b1);
        check("t5_data", ps2_kbd_data, 1'b1);
        check("t5_busy", busy, 1'b0);
        check("t5_full", full, 1'b0);
        reset = 1'b0;
        e0 = rx_edges;
        repeat (150) tick();
        check("t5_no_edges", rx_edges, e0);
        check("t5_busy_after", busy, 1'b0);
        check("t5_overflow_cleared", overflow, 1'b0);

        // 6: write in the same cycle as the stop-bit pop with a full FIFO
        f0 = rx_frames;
        inhibit = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            write_byte(b);
        end
        check("t6_full_before", full, 1'b1);
        inhibit = 1'b0;
        wait_line(1'b0, 1'b0, "t6_start");
        repeat (87) tick();
        check("t6_full_at_pop", full, 1'b1);
        check("t6_clk_stop_low", ps2_kbd_clk, 1'b0);
        b = 8'($urandom_range(0, 255));
        din = b;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
        exp_q.push_back(b);
        check("t6_full_after", full, 1'b1);
        check("t6_overflow", overflow, 1'b0);
        check("t6_gap_after_pop", ps2_kbd_clk, 1'b1);
        wait_busy_low(5000, "t6_busy_low");
        check("t6_frames", rx_frames, f0 + DEPTH + 1);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
